// File: rtl/seq_multiplier_n.sv
// Radix-2 shift-add sequential multiplier with signed/unsigned mode.
// One result every WIDTH+2 cycles; product holds until the next operation completes.
module seq_multiplier_n #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath; operands are reduced to magnitudes so the core is unsigned
  always_comb begin
    state_d = state_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mplr_d  = (signed_mode && multiplier[WIDTH-1])
                    ? (~multiplier + WIDTH'(1)) : multiplier;
          mcand_d = (signed_mode && multiplicand[WIDTH-1])
                    ? (~multiplicand + WIDTH'(1)) : multiplicand;
          neg_d   = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + (PW'(mcand_q) << cnt_q);
        end
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        prod_d  = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mplr_q  <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign product = prod_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Bench for seq_multiplier_n: a 4-bit and an 8-bit instance checked every cycle
// against an arithmetic model, plus directed literal results.
module tb_seq_multiplier_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i [2];
  logic        sm_i    [2];
  logic [7:0]  a_i     [2];
  logic [7:0]  b_i     [2];
  logic [7:0]  prod0;
  logic [15:0] prod1;
  logic        busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier_n #(.WIDTH(4)) u0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .signed_mode(sm_i[0]),
    .multiplier(a_i[0][3:0]), .multiplicand(b_i[0][3:0]),
    .product(prod0), .busy(busy0), .done(done0)
  );

  seq_multiplier_n #(.WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .signed_mode(sm_i[1]),
    .multiplier(a_i[1]), .multiplicand(b_i[1]),
    .product(prod1), .busy(busy1), .done(done1)
  );

  function automatic int wof(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic logic [15:0] get_prod(input int i);
    return (i == 0) ? {8'h00, prod0} : prod1;
  endfunction

  function automatic logic get_busy(input int i);
    return (i == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_done(input int i);
    return (i == 0) ? done0 : done1;
  endfunction

  // Integer product of the operands, wrapped to 2*w bits
  function automatic logic [15:0] ref_mul(input int w, input logic sm,
                                          input logic [7:0] a, input logic [7:0] b);
    int va, vb, p;
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
    if (sm && a[w-1]) va = va - (1 << w);
    if (sm && b[w-1]) vb = vb - (1 << w);
    p = va * vb;
    return 16'(p & ((1 << (2 * w)) - 1));
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted start produces its result W+1 edges later
  logic        busy_m [2];
  logic        done_m [2];
  logic [15:0] prod_m [2];
  logic [15:0] pend_m [2];
  int          rem_m  [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        busy_m[i] <= 1'b0;
        done_m[i] <= 1'b0;
        prod_m[i] <= '0;
        pend_m[i] <= '0;
        rem_m[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        done_m[i] <= 1'b0;
        if (busy_m[i]) begin
          rem_m[i] <= rem_m[i] - 1;
          if (rem_m[i] == 1) begin
            prod_m[i] <= pend_m[i];
            done_m[i] <= 1'b1;
            busy_m[i] <= 1'b0;
          end
        end else if (start_i[i]) begin
          pend_m[i] <= ref_mul(wof(i), sm_i[i], a_i[i], b_i[i]);
          busy_m[i] <= 1'b1;
          rem_m[i]  <= wof(i) + 1;
        end
      end
    end
  end

  // Cycle-by-cycle compare on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), 16'(get_busy(i)), 16'(busy_m[i]));
        chk($sformatf("done%0d", i), 16'(get_done(i)), 16'(done_m[i]));
        chk($sformatf("prod%0d", i), get_prod(i), prod_m[i]);
      end
    end
  end

  // Called just after the accepting edge; counts edges to done and busy cycles
  task automatic wait_done(input int i, output int edges, output int bcnt);
    edges = 0;
    bcnt  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (get_busy(i)) bcnt++;
      if (get_done(i)) return;
      @(posedge clk);
      edges++;
    end
    checks++;
    errors++;
    $display("FAIL timeout_done%0d actual=no_done required=done", i);
  endtask

  task automatic run_op(input int i, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input string nm);
    int edges, bcnt;
    @(posedge clk); #2;
    start_i[i] = 1'b1; sm_i[i] = sm; a_i[i] = a; b_i[i] = b;
    @(posedge clk); #2;
    start_i[i] = 1'b0;
    sm_i[i] = 1'($urandom); a_i[i] = 8'($urandom); b_i[i] = 8'($urandom);
    wait_done(i, edges, bcnt);
    chk({nm, "_prod"}, get_prod(i), exp);
    chk({nm, "_lat"}, 16'(edges), 16'(wof(i) + 1));
    chk({nm, "_busy"}, 16'(bcnt), 16'(wof(i) + 1));
  endtask

  initial begin
    int edges, bcnt;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; sm_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_prod0", get_prod(0), 16'h0000);
    chk("rst_busy0", 16'(busy0), 16'h0000);
    chk("rst_done0", 16'(done0), 16'h0000);
    chk("rst_prod1", get_prod(1), 16'h0000);

    run_op(0, 1'b0, 8'h06, 8'h03, 16'h0012, "u6x3");
    run_op(0, 1'b1, 8'h0D, 8'h05, 16'h00F1, "sm3x5");
    run_op(0, 1'b1, 8'h08, 8'h08, 16'h0040, "sm8xm8");
    run_op(0, 1'b1, 8'h07, 8'h08, 16'h00C8, "s7xm8");
    run_op(0, 1'b0, 8'h0F, 8'h0F, 16'h00E1, "u15x15");
    run_op(0, 1'b0, 8'h0D, 8'h05, 16'h0041, "u13x5");

    // start held high; operands change mid-CALC, second op issues right after done
    @(posedge clk); #2;
    start_i[0] = 1'b1; sm_i[0] = 1'b0; a_i[0] = 8'h06; b_i[0] = 8'h03;
    @(posedge clk); #2;
    a_i[0] = 8'h02; b_i[0] = 8'h07;
    wait_done(0, edges, bcnt);
    chk("hold_first", get_prod(0), 16'h0012);
    @(posedge clk); #2;
    start_i[0] = 1'b0;
    chk("hold_reissue_busy", 16'(busy0), 16'h0001);
    wait_done(0, edges, bcnt);
    chk("hold_second", get_prod(0), 16'h000E);
    chk("hold_second_lat", 16'(edges), 16'd5);

    // asynchronous reset two edges into CALC
    @(posedge clk); #2;
    start_i[0] = 1'b1; sm_i[0] = 1'b0; a_i[0] = 8'h03; b_i[0] = 8'h03;
    @(posedge clk); #2;
    start_i[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_prod", get_prod(0), 16'h0000);
    chk("midrst_busy", 16'(busy0), 16'h0000);
    chk("midrst_done", 16'(done0), 16'h0000);
    #2 rst = 1'b0;
    repeat (8) @(posedge clk);
    run_op(0, 1'b0, 8'h02, 8'h02, 16'h0004, "u2x2");

    run_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_255x255");
    run_op(1, 1'b1, 8'h80, 8'h80, 16'h4000, "w8_m128sq");
    run_op(1, 1'b0, 8'h00, 8'hC8, 16'h0000, "w8_0x200");

    // random traffic on both instances, checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 2; i++) begin
        start_i[i] = ($urandom_range(0, 3) == 0);
        sm_i[i]    = 1'($urandom);
        a_i[i]     = (i == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        b_i[i]     = (i == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      end
    end
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
